// File: rtl/fare_accum_if.sv
// Handshake/bus bundle for fare_accum: pulse qualifiers, tariff table and BCD total.
// The master side drives the pulse/tariff inputs; the slave side is the accumulator.
interface fare_accum_if #(
   parameter int DIGITS      = 4,
   parameter int UNIT_DIGITS = 3,
   parameter int NUM_RATES   = 2
);
   localparam int RSEL_W = (NUM_RATES > 1) ? $clog2(NUM_RATES) : 1;

   logic                               fare_pulse;
   logic                               en;
   logic                               hold;
   logic                               clr;
   logic [RSEL_W-1:0]                  rate_sel;
   logic [NUM_RATES*UNIT_DIGITS*4-1:0] unit_fare_bus;
   logic [DIGITS*4-1:0]                fare_bcd;
   logic                               busy;
   logic                               upd;
   logic                               sat;
   logic                               ovf;

   modport master (
      output fare_pulse, en, hold, clr, rate_sel, unit_fare_bus,
      input  fare_bcd, busy, upd, sat, ovf
   );

   modport slave (
      input  fare_pulse, en, hold, clr, rate_sel, unit_fare_bus,
      output fare_bcd, busy, upd, sat, ovf
   );
endinterface

// File: rtl/fare_accum.sv
// Digit-serial BCD fare accumulator with a tariff table and a 7-deep pulse queue.
// Optional feature macro FARE_SAT_EN: saturate the total at all 9s instead of wrapping.
module fare_accum #(
   parameter int DIGITS      = 4,
   parameter int UNIT_DIGITS = 3,
   parameter int NUM_RATES   = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   fare_accum_if.slave   bus
);
   localparam int IDX_W  = $clog2(DIGITS);
   localparam int UNIT_W = UNIT_DIGITS * 4;

   typedef enum logic [1:0] {IDLE, ADD, COMMIT} state_t;

   state_t                state_reg, state_next;
   logic [DIGITS*4-1:0]   fare_reg;
   logic [DIGITS*4-1:0]   shadow_reg;
   logic [DIGITS*4-1:0]   addend_reg;
   logic [DIGITS*4-1:0]   addend_sel;
   logic [IDX_W-1:0]      idx_reg;
   logic [2:0]            pending_reg;
   logic                  carry_reg;
   logic                  upd_reg;
   logic                  ovf_reg;
   logic                  qp;
   logic                  request;
   logic                  last_digit;
   logic [UNIT_W-1:0]     rates [NUM_RATES];
   logic [UNIT_W-1:0]     tariff;
   logic [3:0]            acc_dig;
   logic [3:0]            add_dig;
   logic [3:0]            sum_dig;
   logic [4:0]            sum_raw;
   logic                  sum_carry;

   assign qp         = bus.fare_pulse & bus.en & ~bus.hold;
   assign request    = qp | (pending_reg != 3'd0);
   assign last_digit = (idx_reg == IDX_W'(DIGITS - 1));

   for (genvar gi = 0; gi < NUM_RATES; gi++) begin : g_rates
      assign rates[gi] = bus.unit_fare_bus[gi*UNIT_W +: UNIT_W];
   end

   // Out-of-range selectors fall back to rate 0.
   always_comb begin
      tariff = rates[0];
      for (int r = 1; r < NUM_RATES; r++) begin
         if (bus.rate_sel == $bits(bus.rate_sel)'(r)) tariff = rates[r];
      end
   end

   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_addend
      if (gi < UNIT_DIGITS) begin : g_unit
         assign addend_sel[gi*4 +: 4] = (tariff[gi*4 +: 4] > 4'd9) ? 4'd0 : tariff[gi*4 +: 4];
      end else begin : g_ext
         assign addend_sel[gi*4 +: 4] = 4'd0;
      end
   end

   always_comb begin
      acc_dig   = fare_reg[idx_reg*4 +: 4];
      add_dig   = addend_reg[idx_reg*4 +: 4];
      sum_raw   = 5'(acc_dig) + 5'(add_dig) + 5'(carry_reg);
      sum_dig   = sum_raw[3:0];
      sum_carry = 1'b0;
      if (sum_raw > 5'd9) begin
         sum_dig   = 4'(sum_raw - 5'd10);
         sum_carry = 1'b1;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (request) state_next = ADD;
         ADD:     if (last_digit) state_next = COMMIT;
         COMMIT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (bus.clr) state_next = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

`ifdef FARE_SAT_EN
   logic sat_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              sat_reg <= 1'b0;
      else if (bus.clr)                        sat_reg <= 1'b0;
      else if (state_reg == COMMIT && carry_reg) sat_reg <= 1'b1;
   end

   assign bus.sat = sat_reg;
`else
   assign bus.sat = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fare_reg    <= '0;
         shadow_reg  <= '0;
         addend_reg  <= '0;
         idx_reg     <= '0;
         pending_reg <= 3'd0;
         carry_reg   <= 1'b0;
         upd_reg     <= 1'b0;
         ovf_reg     <= 1'b0;
      end else if (bus.clr) begin
         fare_reg    <= '0;
         idx_reg     <= '0;
         pending_reg <= 3'd0;
         carry_reg   <= 1'b0;
         upd_reg     <= 1'b0;
         ovf_reg     <= 1'b0;
      end else begin
         upd_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (request) begin
                  addend_reg  <= addend_sel;
                  pending_reg <= pending_reg + {2'b00, qp} - 3'd1;
                  idx_reg     <= '0;
                  carry_reg   <= 1'b0;
               end
            end
            ADD: begin
               shadow_reg[idx_reg*4 +: 4] <= sum_dig;
               carry_reg                  <= sum_carry;
               idx_reg                    <= idx_reg + IDX_W'(1);
            end
            COMMIT: begin
               upd_reg <= 1'b1;
`ifdef FARE_SAT_EN
               // Once saturated, later adds are pinned at all 9s as well.
               if (carry_reg || sat_reg) fare_reg <= {DIGITS{4'h9}};
               else                      fare_reg <= shadow_reg;
`else
               fare_reg <= shadow_reg;
`endif
            end
            default: ;
         endcase
         // Pulses arriving during an add are queued; a full queue drops them.
         if (state_reg != IDLE && qp) begin
            if (pending_reg == 3'd7) ovf_reg     <= 1'b1;
            else                     pending_reg <= pending_reg + 3'd1;
         end
      end
   end

   assign bus.fare_bcd = fare_reg;
   assign bus.busy     = (state_reg != IDLE);
   assign bus.upd      = upd_reg;
   assign bus.ovf      = ovf_reg;
endmodule
